// File: rtl/trans_buffers_nlane_if.sv
// Lane-buffer bus bundle: TCDM-side per-lane push/pop and EXT-side wide beats.
// The slave modport is the buffer view; the master modport is the environment view.
interface trans_buffers_nlane_if #(
    parameter int unsigned NB_LANES = 2,
    parameter int unsigned LANE_DW  = 32
);
    localparam int unsigned DW = NB_LANES * LANE_DW;
    localparam int unsigned SW = DW / 8;

    logic [DW-1:0]       tx_push_dat_i;
    logic [NB_LANES-1:0] tx_push_req_i;
    logic [NB_LANES-1:0] tx_push_gnt_o;
    logic [DW-1:0]       tx_pop_dat_o;
    logic                tx_pop_req_i;
    logic                tx_pop_gnt_o;

    logic [DW-1:0]       rx_push_dat_i;
    logic [SW-1:0]       rx_push_strb_i;
    logic                rx_push_req_i;
    logic                rx_push_gnt_o;
    logic [DW-1:0]       rx_pop_dat_o;
    logic [SW-1:0]       rx_pop_strb_o;
    logic [NB_LANES-1:0] rx_pop_req_i;
    logic [NB_LANES-1:0] rx_pop_gnt_o;

    modport slave (
        input  tx_push_dat_i, tx_push_req_i, tx_pop_req_i,
        input  rx_push_dat_i, rx_push_strb_i, rx_push_req_i, rx_pop_req_i,
        output tx_push_gnt_o, tx_pop_dat_o, tx_pop_gnt_o,
        output rx_push_gnt_o, rx_pop_dat_o, rx_pop_strb_o, rx_pop_gnt_o
    );

    modport master (
        output tx_push_dat_i, tx_push_req_i, tx_pop_req_i,
        output rx_push_dat_i, rx_push_strb_i, rx_push_req_i, rx_pop_req_i,
        input  tx_push_gnt_o, tx_pop_dat_o, tx_pop_gnt_o,
        input  rx_push_gnt_o, rx_pop_dat_o, rx_pop_strb_o, rx_pop_gnt_o
    );
endinterface

// File: rtl/trans_buffers_nlane.sv
// N-lane transfer buffers: per-lane TX FIFOs joined into wide EXT beats, wide RX beats split into per-lane FIFOs.
// Optional sticky protocol-error flag err_o under `define TRANS_BUFFERS_NLANE_ERR_EN.
module trans_buffers_nlane #(
    parameter int unsigned NB_LANES = 2,
    parameter int unsigned LANE_DW  = 32,
    parameter int unsigned TX_DEPTH = 2,
    parameter int unsigned RX_DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic test_mode_i,
    input  logic flush_i,
    input  logic rx_skip_en_i,
    trans_buffers_nlane_if.slave bus
`ifdef TRANS_BUFFERS_NLANE_ERR_EN
    ,
    output logic err_o
`endif
);
    localparam int unsigned STRB_W = LANE_DW / 8;
    localparam int unsigned DW     = NB_LANES * LANE_DW;
    localparam int unsigned SW     = NB_LANES * STRB_W;
    localparam int unsigned RX_EW  = LANE_DW + STRB_W;
    localparam int unsigned TX_CW  = $clog2(TX_DEPTH + 1);
    localparam int unsigned RX_CW  = $clog2(RX_DEPTH + 1);
    localparam int unsigned TX_PW  = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned RX_PW  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

    logic [NB_LANES-1:0] tx_full, tx_empty, tx_push_fire;
    logic [NB_LANES-1:0] rx_full, rx_empty, rx_need, rx_lane_push, rx_pop_fire;
    logic                tx_pop_fire, rx_push_fire;
    logic [DW-1:0]       tx_head_dat, rx_head_dat;
    logic [SW-1:0]       rx_head_strb;

    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;

    // Handshakes: grants come from occupancy only, and flush masks them all.
    assign bus.tx_push_gnt_o = flush_i ? '0 : ~tx_full;
    assign bus.tx_pop_gnt_o  = ~flush_i & ~(|tx_empty);
    assign tx_push_fire      = bus.tx_push_req_i & bus.tx_push_gnt_o;
    assign tx_pop_fire       = bus.tx_pop_req_i & bus.tx_pop_gnt_o;

    assign bus.rx_push_gnt_o = ~flush_i & ~(|(rx_need & rx_full));
    assign rx_push_fire      = bus.rx_push_req_i & bus.rx_push_gnt_o;
    assign rx_lane_push      = {NB_LANES{rx_push_fire}} & rx_need;
    assign bus.rx_pop_gnt_o  = flush_i ? '0 : ~rx_empty;
    assign rx_pop_fire       = bus.rx_pop_req_i & bus.rx_pop_gnt_o;

    assign bus.tx_pop_dat_o  = tx_head_dat;
    assign bus.rx_pop_dat_o  = rx_head_dat;
    assign bus.rx_pop_strb_o = rx_head_strb;

    for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
        logic [LANE_DW-1:0] tx_mem [TX_DEPTH];
        logic [TX_PW-1:0]   tx_wr, tx_rd;
        logic [TX_CW-1:0]   tx_cnt;
        logic [RX_EW-1:0]   rx_mem [RX_DEPTH];
        logic [RX_PW-1:0]   rx_wr, rx_rd;
        logic [RX_CW-1:0]   rx_cnt;
        logic [RX_EW-1:0]   rx_head;

        assign tx_full[i]  = (tx_cnt == TX_CW'(TX_DEPTH));
        assign tx_empty[i] = (tx_cnt == '0);
        assign rx_full[i]  = (rx_cnt == RX_CW'(RX_DEPTH));
        assign rx_empty[i] = (rx_cnt == '0);
        // A lane is only needed by a beat if skipping is off or it carries live bytes.
        assign rx_need[i]  = ~rx_skip_en_i | (|bus.rx_push_strb_i[i*STRB_W +: STRB_W]);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                tx_wr  <= '0;
                tx_rd  <= '0;
                tx_cnt <= '0;
            end else if (flush_i) begin
                tx_wr  <= '0;
                tx_rd  <= '0;
                tx_cnt <= '0;
            end else begin
                if (tx_push_fire[i])
                    tx_wr <= (tx_wr == TX_PW'(TX_DEPTH - 1)) ? '0 : tx_wr + TX_PW'(1);
                if (tx_pop_fire)
                    tx_rd <= (tx_rd == TX_PW'(TX_DEPTH - 1)) ? '0 : tx_rd + TX_PW'(1);
                case ({tx_push_fire[i], tx_pop_fire})
                    2'b10:   tx_cnt <= tx_cnt + TX_CW'(1);
                    2'b01:   tx_cnt <= tx_cnt - TX_CW'(1);
                    default: tx_cnt <= tx_cnt;
                endcase
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rx_wr  <= '0;
                rx_rd  <= '0;
                rx_cnt <= '0;
            end else if (flush_i) begin
                rx_wr  <= '0;
                rx_rd  <= '0;
                rx_cnt <= '0;
            end else begin
                if (rx_lane_push[i])
                    rx_wr <= (rx_wr == RX_PW'(RX_DEPTH - 1)) ? '0 : rx_wr + RX_PW'(1);
                if (rx_pop_fire[i])
                    rx_rd <= (rx_rd == RX_PW'(RX_DEPTH - 1)) ? '0 : rx_rd + RX_PW'(1);
                case ({rx_lane_push[i], rx_pop_fire[i]})
                    2'b10:   rx_cnt <= rx_cnt + RX_CW'(1);
                    2'b01:   rx_cnt <= rx_cnt - RX_CW'(1);
                    default: rx_cnt <= rx_cnt;
                endcase
            end
        end

        // Storage carries no reset; contents are qualified by the counts.
        always_ff @(posedge clk_i) begin
            if (tx_push_fire[i])
                tx_mem[tx_wr] <= bus.tx_push_dat_i[i*LANE_DW +: LANE_DW];
            if (rx_lane_push[i])
                rx_mem[rx_wr] <= {bus.rx_push_strb_i[i*STRB_W +: STRB_W],
                                  bus.rx_push_dat_i[i*LANE_DW +: LANE_DW]};
        end

        assign rx_head                               = rx_mem[rx_rd];
        assign tx_head_dat[i*LANE_DW +: LANE_DW]     = tx_mem[tx_rd];
        assign rx_head_dat[i*LANE_DW +: LANE_DW]     = rx_head[LANE_DW-1:0];
        assign rx_head_strb[i*STRB_W +: STRB_W]      = rx_head[RX_EW-1:LANE_DW];
    end

`ifdef TRANS_BUFFERS_NLANE_ERR_EN
    localparam int unsigned STALL_W   = 11;
    localparam int unsigned STALL_LIM = 1024;

    logic [STALL_W-1:0] stall_cnt;
    logic               rx_stall, err_set;

    assign rx_stall = bus.rx_push_req_i & ~bus.rx_push_gnt_o;
    // Stall error fires on the 1025th consecutive refused cycle.
    assign err_set  = (|(bus.tx_push_req_i & tx_full))
                    | (bus.tx_pop_req_i & ~bus.tx_pop_gnt_o)
                    | (rx_stall & (stall_cnt >= STALL_W'(STALL_LIM)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
            err_o     <= 1'b0;
        end else if (flush_i) begin
            stall_cnt <= '0;
            err_o     <= 1'b0;
        end else begin
            if (!rx_stall)
                stall_cnt <= '0;
            else if (stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_W'(1);
            if (err_set)
                err_o <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_trans_buffers_nlane.sv
// Directed table-driven bench for trans_buffers_nlane (2 lanes x 32 bit, depth 2).
module tb_trans_buffers_nlane;
    logic clk = 1'b0;
    logic rst_ni, test_mode, flush, skip;
`ifdef TRANS_BUFFERS_NLANE_ERR_EN
    logic err;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trans_buffers_nlane_if #(.NB_LANES(2), .LANE_DW(32)) bus ();

    trans_buffers_nlane #(.NB_LANES(2), .LANE_DW(32), .TX_DEPTH(2), .RX_DEPTH(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .test_mode_i (test_mode),
        .flush_i     (flush),
        .rx_skip_en_i(skip),
        .bus         (bus)
`ifdef TRANS_BUFFERS_NLANE_ERR_EN
        ,
        .err_o       (err)
`endif
    );

    typedef struct {
        logic [1:0]  req;
        logic [31:0] d1, d0;
        logic        pop;
        logic [1:0]  e_gnt;
        logic        e_vld;
        logic [63:0] e_dat;
    } tx_vec_t;

    typedef struct {
        logic        skp;
        logic        req;
        logic [63:0] dat;
        logic [7:0]  strb;
        logic [1:0]  pop;
        logic        e_gnt;
        logic [1:0]  e_vld;
        logic [31:0] e_d1, e_d0;
        logic [3:0]  e_s1, e_s0;
    } rx_vec_t;

    tx_vec_t tx_tab[$];
    rx_vec_t rx_tab[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0;
        skip  = 1'b0;
        bus.tx_push_dat_i  = '0;
        bus.tx_push_req_i  = '0;
        bus.tx_pop_req_i   = 1'b0;
        bus.rx_push_dat_i  = '0;
        bus.rx_push_strb_i = '0;
        bus.rx_push_req_i  = 1'b0;
        bus.rx_pop_req_i   = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // TX: join lanes, lockstep pop, full-with-pop refusal
        tx_tab.push_back(tx_vec_t'{2'b00, 32'h0,  32'h0,  1'b0, 2'b11, 1'b0, 64'h0});
        tx_tab.push_back(tx_vec_t'{2'b01, 32'h0,  32'hA0, 1'b0, 2'b11, 1'b0, 64'h0});
        tx_tab.push_back(tx_vec_t'{2'b01, 32'h0,  32'hA1, 1'b0, 2'b11, 1'b0, 64'h0});
        tx_tab.push_back(tx_vec_t'{2'b10, 32'hB0, 32'h0,  1'b0, 2'b10, 1'b0, 64'h0});
        tx_tab.push_back(tx_vec_t'{2'b00, 32'h0,  32'h0,  1'b0, 2'b10, 1'b1, 64'h000000B0_000000A0});
        tx_tab.push_back(tx_vec_t'{2'b00, 32'h0,  32'h0,  1'b1, 2'b10, 1'b1, 64'h000000B0_000000A0});
        tx_tab.push_back(tx_vec_t'{2'b00, 32'h0,  32'h0,  1'b0, 2'b11, 1'b0, 64'h0});
        tx_tab.push_back(tx_vec_t'{2'b00, 32'h0,  32'h0,  1'b1, 2'b11, 1'b0, 64'h0});
        tx_tab.push_back(tx_vec_t'{2'b10, 32'hB1, 32'h0,  1'b0, 2'b11, 1'b0, 64'h0});
        tx_tab.push_back(tx_vec_t'{2'b00, 32'h0,  32'h0,  1'b0, 2'b11, 1'b1, 64'h000000B1_000000A1});
        tx_tab.push_back(tx_vec_t'{2'b01, 32'h0,  32'hA2, 1'b0, 2'b11, 1'b1, 64'h000000B1_000000A1});
        tx_tab.push_back(tx_vec_t'{2'b01, 32'h0,  32'hA3, 1'b1, 2'b10, 1'b1, 64'h000000B1_000000A1});
        tx_tab.push_back(tx_vec_t'{2'b01, 32'h0,  32'hA3, 1'b0, 2'b11, 1'b0, 64'h0});
        tx_tab.push_back(tx_vec_t'{2'b10, 32'hB2, 32'h0,  1'b0, 2'b10, 1'b0, 64'h0});
        tx_tab.push_back(tx_vec_t'{2'b00, 32'h0,  32'h0,  1'b1, 2'b10, 1'b1, 64'h000000B2_000000A2});
        tx_tab.push_back(tx_vec_t'{2'b10, 32'hB3, 32'h0,  1'b1, 2'b11, 1'b0, 64'h0});
        tx_tab.push_back(tx_vec_t'{2'b00, 32'h0,  32'h0,  1'b1, 2'b11, 1'b1, 64'h000000B3_000000A3});
        tx_tab.push_back(tx_vec_t'{2'b00, 32'h0,  32'h0,  1'b0, 2'b11, 1'b0, 64'h0});

        // RX: lane skip, discard of empty beat, backpressure from one full lane
        rx_tab.push_back(rx_vec_t'{1'b1, 1'b1, 64'h11112222_33334444, 8'h0F, 2'b00, 1'b1, 2'b00, 32'h0,  32'h0,        4'h0, 4'h0});
        rx_tab.push_back(rx_vec_t'{1'b0, 1'b0, 64'h0,                 8'h00, 2'b00, 1'b1, 2'b01, 32'h0,  32'h33334444, 4'h0, 4'hF});
        rx_tab.push_back(rx_vec_t'{1'b0, 1'b0, 64'h0,                 8'h00, 2'b01, 1'b1, 2'b01, 32'h0,  32'h33334444, 4'h0, 4'hF});
        rx_tab.push_back(rx_vec_t'{1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D, 8'h00, 2'b00, 1'b1, 2'b00, 32'h0,  32'h0,        4'h0, 4'h0});
        rx_tab.push_back(rx_vec_t'{1'b0, 1'b0, 64'h0,                 8'h00, 2'b00, 1'b1, 2'b00, 32'h0,  32'h0,        4'h0, 4'h0});
        rx_tab.push_back(rx_vec_t'{1'b0, 1'b1, 64'h000000C1_000000D1, 8'hFF, 2'b00, 1'b1, 2'b00, 32'h0,  32'h0,        4'h0, 4'h0});
        rx_tab.push_back(rx_vec_t'{1'b0, 1'b1, 64'h000000C2_000000D2, 8'hFF, 2'b01, 1'b1, 2'b11, 32'hC1, 32'hD1,       4'hF, 4'hF});
        rx_tab.push_back(rx_vec_t'{1'b0, 1'b1, 64'h000000C3_000000D3, 8'hFF, 2'b01, 1'b0, 2'b11, 32'hC1, 32'hD2,       4'hF, 4'hF});
        rx_tab.push_back(rx_vec_t'{1'b0, 1'b1, 64'h000000C3_000000D3, 8'hFF, 2'b10, 1'b0, 2'b10, 32'hC1, 32'h0,        4'hF, 4'h0});
        rx_tab.push_back(rx_vec_t'{1'b0, 1'b1, 64'h000000C3_000000D3, 8'hFF, 2'b00, 1'b1, 2'b10, 32'hC2, 32'h0,        4'hF, 4'h0});
        rx_tab.push_back(rx_vec_t'{1'b1, 1'b1, 64'h99999999_000000E4, 8'h0F, 2'b00, 1'b1, 2'b11, 32'hC2, 32'hD3,       4'hF, 4'hF});
        rx_tab.push_back(rx_vec_t'{1'b0, 1'b1, 64'h0,                 8'hFF, 2'b11, 1'b0, 2'b11, 32'hC2, 32'hD3,       4'hF, 4'hF});
        rx_tab.push_back(rx_vec_t'{1'b0, 1'b0, 64'h0,                 8'h00, 2'b11, 1'b1, 2'b11, 32'hC3, 32'hE4,       4'hF, 4'hF});
        rx_tab.push_back(rx_vec_t'{1'b0, 1'b0, 64'h0,                 8'h00, 2'b00, 1'b1, 2'b00, 32'h0,  32'h0,        4'h0, 4'h0});

        test_mode = 1'b0;
        rst_ni    = 1'b0;
        idle();
        #12;
        chk("reset tx_push_gnt", 64'(bus.tx_push_gnt_o), 64'h3);
        chk("reset tx_pop_gnt",  64'(bus.tx_pop_gnt_o),  64'h0);
        chk("reset rx_push_gnt", 64'(bus.rx_push_gnt_o), 64'h1);
        chk("reset rx_pop_gnt",  64'(bus.rx_pop_gnt_o),  64'h0);
        rst_ni = 1'b1;
        cyc();

        foreach (tx_tab[k]) begin
            idle();
            bus.tx_push_req_i = tx_tab[k].req;
            bus.tx_push_dat_i = {tx_tab[k].d1, tx_tab[k].d0};
            bus.tx_pop_req_i  = tx_tab[k].pop;
            #2;
            chk($sformatf("tx[%0d] push_gnt", k), 64'(bus.tx_push_gnt_o), 64'(tx_tab[k].e_gnt));
            chk($sformatf("tx[%0d] pop_gnt", k),  64'(bus.tx_pop_gnt_o),  64'(tx_tab[k].e_vld));
            if (tx_tab[k].e_vld)
                chk($sformatf("tx[%0d] pop_dat", k), bus.tx_pop_dat_o, tx_tab[k].e_dat);
            cyc();
        end

        foreach (rx_tab[k]) begin
            idle();
            skip               = rx_tab[k].skp;
            bus.rx_push_req_i  = rx_tab[k].req;
            bus.rx_push_dat_i  = rx_tab[k].dat;
            bus.rx_push_strb_i = rx_tab[k].strb;
            bus.rx_pop_req_i   = rx_tab[k].pop;
            #2;
            chk($sformatf("rx[%0d] push_gnt", k), 64'(bus.rx_push_gnt_o), 64'(rx_tab[k].e_gnt));
            chk($sformatf("rx[%0d] pop_gnt", k),  64'(bus.rx_pop_gnt_o),  64'(rx_tab[k].e_vld));
            if (rx_tab[k].e_vld[0]) begin
                chk($sformatf("rx[%0d] l0 dat", k),  64'(bus.rx_pop_dat_o[31:0]), 64'(rx_tab[k].e_d0));
                chk($sformatf("rx[%0d] l0 strb", k), 64'(bus.rx_pop_strb_o[3:0]), 64'(rx_tab[k].e_s0));
            end
            if (rx_tab[k].e_vld[1]) begin
                chk($sformatf("rx[%0d] l1 dat", k),  64'(bus.rx_pop_dat_o[63:32]), 64'(rx_tab[k].e_d1));
                chk($sformatf("rx[%0d] l1 strb", k), 64'(bus.rx_pop_strb_o[7:4]), 64'(rx_tab[k].e_s1));
            end
            cyc();
        end

        // Flush with both sides half full and pushes pending
        idle();
        bus.tx_push_req_i  = 2'b11;
        bus.tx_push_dat_i  = 64'h00000006_00000005;
        bus.rx_push_req_i  = 1'b1;
        bus.rx_push_dat_i  = 64'h00000008_00000007;
        bus.rx_push_strb_i = 8'hFF;
        cyc();
        idle();
        #2;
        chk("pre-flush tx_pop_gnt", 64'(bus.tx_pop_gnt_o), 64'h1);
        chk("pre-flush rx_pop_gnt", 64'(bus.rx_pop_gnt_o), 64'h3);
        cyc();
        flush              = 1'b1;
        bus.tx_push_req_i  = 2'b11;
        bus.rx_push_req_i  = 1'b1;
        bus.rx_push_strb_i = 8'hFF;
        #2;
        chk("flush tx_push_gnt", 64'(bus.tx_push_gnt_o), 64'h0);
        chk("flush tx_pop_gnt",  64'(bus.tx_pop_gnt_o),  64'h0);
        chk("flush rx_push_gnt", 64'(bus.rx_push_gnt_o), 64'h0);
        chk("flush rx_pop_gnt",  64'(bus.rx_pop_gnt_o),  64'h0);
        cyc();
        idle();
        #2;
        chk("post-flush tx_push_gnt", 64'(bus.tx_push_gnt_o), 64'h3);
        chk("post-flush tx_pop_gnt",  64'(bus.tx_pop_gnt_o),  64'h0);
        chk("post-flush rx_push_gnt", 64'(bus.rx_push_gnt_o), 64'h1);
        chk("post-flush rx_pop_gnt",  64'(bus.rx_pop_gnt_o),  64'h0);
        cyc();

        // Asynchronous reset in the middle of a transfer
        bus.tx_push_req_i  = 2'b11;
        bus.tx_push_dat_i  = 64'h00000022_00000011;
        bus.rx_push_req_i  = 1'b1;
        bus.rx_push_strb_i = 8'hFF;
        cyc();
        idle();
        #2;
        chk("pre-reset tx_pop_gnt", 64'(bus.tx_pop_gnt_o), 64'h1);
        chk("pre-reset tx_pop_dat", bus.tx_pop_dat_o, 64'h00000022_00000011);
        rst_ni = 1'b0;
        #1;
        chk("async reset tx_pop_gnt", 64'(bus.tx_pop_gnt_o), 64'h0);
        chk("async reset rx_pop_gnt", 64'(bus.rx_pop_gnt_o), 64'h0);
        #2;
        rst_ni = 1'b1;
        cyc();

`ifdef TRANS_BUFFERS_NLANE_ERR_EN
        #1;
        chk("err after reset", 64'(err), 64'h0);
        bus.tx_pop_req_i = 1'b1;
        cyc();
        idle();
        chk("err set by empty pop", 64'(err), 64'h1);
        cyc();
        cyc();
        cyc();
        chk("err sticky", 64'(err), 64'h1);
        flush = 1'b1;
        cyc();
        idle();
        chk("err cleared by flush", 64'(err), 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
